// File: rtl/sar_ctrl.sv
// Successive-approximation controller for a differential monotonic-switching SAR ADC.
// Optional comparator watchdog enabled by defining SAR_CMP_TIMEOUT_EN.
module sar_ctrl #(
  parameter int ADC_BITS      = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int CMP_TIMEOUT   = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  output logic                busy,
  output logic                sample,
  output logic                comp_trig,
  input  logic                comp_valid,
  input  logic                comp_out,
  output logic [ADC_BITS-1:1] dacp_h,
  output logic [ADC_BITS-1:1] dacp_l,
  output logic [ADC_BITS-1:1] dacn_h,
  output logic [ADC_BITS-1:1] dacn_l,
  output logic [ADC_BITS-1:0] dout,
  output logic                dout_valid,
  output logic                timeout_flag
);

  localparam int BW  = $clog2(ADC_BITS);
  localparam int SCW = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [BW-1:0]  BIT_MSB   = BW'(ADC_BITS - 1);
  localparam logic [SCW-1:0] SAMP_LAST = SCW'(SAMPLE_CYCLES - 1);

  if (SAMPLE_CYCLES < 1 || CMP_TIMEOUT < 1) begin : g_param_check
    $error("sar_ctrl: SAMPLE_CYCLES and CMP_TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_TRIG,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SCW-1:0]      samp_cnt_q, samp_cnt_d;
  logic [BW-1:0]       bit_idx_q, bit_idx_d;
  logic                busy_d, sample_d, comp_trig_d, dout_valid_d;
  logic [ADC_BITS-1:1] dacp_h_d, dacp_l_d, dacn_h_d, dacn_l_d;
  logic [ADC_BITS-1:0] dout_d;
  logic                decide, dbit;

`ifdef SAR_CMP_TIMEOUT_EN
  localparam int TW = $clog2(CMP_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(CMP_TIMEOUT - 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          tflag_d;
`endif

  // NOTE: every variable gets a hold/default value before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    samp_cnt_d   = samp_cnt_q;
    bit_idx_d    = bit_idx_q;
    busy_d       = busy;
    sample_d     = sample;
    comp_trig_d  = 1'b0;
    dout_valid_d = 1'b0;
    dacp_h_d     = dacp_h;
    dacp_l_d     = dacp_l;
    dacn_h_d     = dacn_h;
    dacn_l_d     = dacn_l;
    dout_d       = dout;
    decide       = 1'b0;
    dbit         = 1'b0;
`ifdef SAR_CMP_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    tflag_d      = timeout_flag;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SAMPLE;
          busy_d     = 1'b1;
          sample_d   = 1'b1;
          samp_cnt_d = '0;
          bit_idx_d  = BIT_MSB;
          dacp_h_d   = '1;
          dacp_l_d   = '0;
          dacn_h_d   = '1;
          dacn_l_d   = '0;
          dout_d     = '0;
`ifdef SAR_CMP_TIMEOUT_EN
          tflag_d    = 1'b0;
`endif
        end
      end

      S_SAMPLE: begin
        if (samp_cnt_q == SAMP_LAST) begin
          state_d     = S_TRIG;
          sample_d    = 1'b0;
          comp_trig_d = 1'b1;
        end else begin
          samp_cnt_d = samp_cnt_q + 1'b1;
        end
      end

      S_TRIG: begin
        state_d = S_WAIT;
`ifdef SAR_CMP_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      S_WAIT: begin
`ifdef SAR_CMP_TIMEOUT_EN
        // A late strobe arriving in the expiry cycle still supplies the real decision.
        decide     = comp_valid || (wait_cnt_q == TO_LAST);
        dbit       = comp_valid ? comp_out : 1'b1;
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (decide && !comp_valid) tflag_d = 1'b1;
`else
        decide = comp_valid;
        dbit   = comp_out;
`endif
        if (decide) begin
          dout_d[bit_idx_q] = dbit;
          // Cap index 0 does not exist, so the final decision switches nothing.
          for (int i = 1; i < ADC_BITS; i++) begin
            if (bit_idx_q == BW'(i)) begin
              if (dbit) begin
                dacp_h_d[i] = 1'b0;
                dacp_l_d[i] = 1'b1;
              end else begin
                dacn_h_d[i] = 1'b0;
                dacn_l_d[i] = 1'b1;
              end
            end
          end
          if (bit_idx_q == '0) begin
            state_d      = S_DONE;
            dout_valid_d = 1'b1;
          end else begin
            state_d     = S_TRIG;
            comp_trig_d = 1'b1;
            bit_idx_d   = bit_idx_q - 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      busy       <= 1'b0;
      sample     <= 1'b0;
      comp_trig  <= 1'b0;
      dout_valid <= 1'b0;
      dacp_h     <= '1;
      dacp_l     <= '0;
      dacn_h     <= '1;
      dacn_l     <= '0;
      dout       <= '0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      busy       <= busy_d;
      sample     <= sample_d;
      comp_trig  <= comp_trig_d;
      dout_valid <= dout_valid_d;
      dacp_h     <= dacp_h_d;
      dacp_l     <= dacp_l_d;
      dacn_h     <= dacn_h_d;
      dacn_l     <= dacn_l_d;
      dout       <= dout_d;
    end
  end

`ifdef SAR_CMP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      timeout_flag <= tflag_d;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sar_ctrl.sv
// Self-checking bench for sar_ctrl: comparator responder plus expected-result scoreboard.
// Exercises the watchdog path too when compiled with SAR_CMP_TIMEOUT_EN.
module tb_sar_ctrl;

  localparam int ADC_BITS = 8;
  localparam int SC       = 2;
  localparam int CT       = 4;

  logic                clk, rstn, start;
  logic                busy, sample, comp_trig, comp_valid, comp_out;
  logic [ADC_BITS-1:1] dacp_h, dacp_l, dacn_h, dacn_l;
  logic [ADC_BITS-1:0] dout;
  logic                dout_valid, timeout_flag;

  logic                resp_valid, resp_out, idle_valid, idle_out;
  logic [ADC_BITS-1:0] cur_bits;
  int                  cur_lat, cur_hold, trig_k;

  assign comp_valid = resp_valid | idle_valid;
  assign comp_out   = resp_valid ? resp_out : idle_out;

  sar_ctrl #(
    .ADC_BITS     (ADC_BITS),
    .SAMPLE_CYCLES(SC),
    .CMP_TIMEOUT  (CT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .busy        (busy),
    .sample      (sample),
    .comp_trig   (comp_trig),
    .comp_valid  (comp_valid),
    .comp_out    (comp_out),
    .dacp_h      (dacp_h),
    .dacp_l      (dacp_l),
    .dacn_h      (dacn_h),
    .dacn_l      (dacn_l),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADC_BITS-1:0] dout;
    logic [ADC_BITS-1:1] dacp_l;
    logic [ADC_BITS-1:1] dacp_h;
    logic [ADC_BITS-1:1] dacn_l;
    logic [ADC_BITS-1:1] dacn_h;
    logic                tflag;
    int                  lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: decision k resolves bit 8-k; a withheld decision is forced to 1.
  function automatic exp_t build_exp(input logic [ADC_BITS-1:0] bits, input int lat,
                                     input int hold_k);
    exp_t e;
    e.dout   = '0;
    e.dacp_l = '0;
    e.tflag  = 1'b0;
    e.lat    = SC + 2 * ADC_BITS + 1;
    for (int k = 1; k <= ADC_BITS; k++) begin
      int   b;
      logic d;
      b = ADC_BITS - k;
      d = (hold_k == k) ? 1'b1 : bits[b];
      e.dout[b] = d;
      if (b >= 1) e.dacp_l[b] = d;
      if (hold_k == k) begin
        e.tflag = 1'b1;
        e.lat += CT - 1;
      end else begin
        e.lat += lat - 1;
      end
    end
    e.dacp_h = ~e.dacp_l;
    e.dacn_l = ~e.dacp_l;
    e.dacn_h = e.dacp_l;
    return e;
  endfunction

  // Comparator model: answers each trigger cur_lat cycles later, except decision cur_hold.
  initial begin
    resp_valid = 1'b0;
    resp_out   = 1'b0;
    trig_k     = 0;
    forever begin
      @(negedge clk);
      if (sample) trig_k = 0;
      if (comp_trig === 1'b1) begin
        trig_k++;
        if (trig_k != cur_hold) begin
          repeat (cur_lat) @(posedge clk);
          #1;
          resp_valid = 1'b1;
          resp_out   = cur_bits[ADC_BITS-trig_k];
          @(posedge clk);
          #1;
          resp_valid = 1'b0;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dacp_h"}, dacp_h, 7'h7F);
    check({tag, "_dacn_h"}, dacn_h, 7'h7F);
    check({tag, "_dacp_l"}, dacp_l, 0);
    check({tag, "_dacn_l"}, dacn_l, 0);
    check({tag, "_strobes"}, {busy, sample, comp_trig, dout_valid, timeout_flag}, 0);
  endtask

  task automatic run_conv(input logic [ADC_BITS-1:0] bits, input int lat, input int hold_k,
                          input int rst_cycle, input bit poke_start);
    exp_t e, got_e;
    bit   seen;
    logic saw11;
    e        = build_exp(bits, lat, hold_k);
    cur_bits = bits;
    cur_lat  = lat;
    cur_hold = hold_k;
    seen     = 1'b0;
    saw11    = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (rst_cycle == 0) sb.push_back(e);
    for (int cyc = 1; cyc <= e.lat + 2; cyc++) begin
      @(negedge clk);
      saw11 = saw11 | (|(dacp_h & dacp_l)) | (|(dacn_h & dacn_l));
      if (cyc == 1)      check("busy_first", busy, 1);
      if (cyc == SC)     check("sample_hi", sample, 1);
      if (cyc == SC + 1) check("sample_lo_trig", {sample, comp_trig}, 2'b01);
      if (cyc == rst_cycle) begin
        rstn = 1'b0;
        #1 check_reset("mid_rst");
      end
      if (rst_cycle != 0 && cyc == rst_cycle + 2) rstn = 1'b1;
      if (poke_start) begin
        if (cyc == SC + 2 || cyc == e.lat) start = 1'b1;
        if (cyc == SC + 3 || cyc == e.lat + 1) start = 1'b0;
      end
      if (dout_valid) begin
        if (rst_cycle != 0 || sb.size() == 0) begin
          check("unexpected_dv", dout_valid, 0);
        end else begin
          got_e = sb.pop_front();
          seen  = 1'b1;
          check("dv_cycle", cyc, got_e.lat);
          check("dout", dout, got_e.dout);
          check("dacp_l", dacp_l, got_e.dacp_l);
          check("dacp_h", dacp_h, got_e.dacp_h);
          check("dacn_l", dacn_l, got_e.dacn_l);
          check("dacn_h", dacn_h, got_e.dacn_h);
          check("timeout_flag", timeout_flag, got_e.tflag);
        end
      end
      if (rst_cycle == 0) begin
        if (cyc == e.lat)     check("busy_done", busy, 1);
        if (cyc == e.lat + 1) check("busy_idle", busy, 0);
        if (cyc == e.lat + 2) check("busy_after_done_start", busy, 0);
      end
    end
    start = 1'b0;
    if (rst_cycle == 0) begin
      check("dv_seen", seen, 1);
      if (!seen && sb.size() != 0) void'(sb.pop_front());
    end
    check("no_11_code", saw11, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    idle_valid = 1'b0;
    idle_out   = 1'b0;
    cur_bits   = '0;
    cur_lat    = 1;
    cur_hold   = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rstn = 1'b1;

    // Nominal pattern with start pokes in WAIT and DONE.
    run_conv(8'hB2, 1, 0, 0, 1'b1);
    check("nominal_dout_const", dout, 8'hB2);

    // Strobes in IDLE must not disturb the held result.
    @(negedge clk);
    idle_valid = 1'b1;
    idle_out   = 1'b1;
    repeat (2) @(negedge clk);
    idle_out   = 1'b0;
    @(negedge clk);
    idle_valid = 1'b0;
    @(negedge clk);
    check("idle_cv_dout", dout, 8'hB2);
    check("idle_cv_dacp_l", dacp_l, 7'b1011001);
    check("idle_cv_busy", {busy, dout_valid}, 0);

    // Slow comparator.
    run_conv(8'hB2, 3, 0, 0, 1'b0);

    // Boundary and random patterns.
    run_conv(8'h00, 1, 0, 0, 1'b0);
    run_conv(8'hFF, 2, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_conv(8'($urandom), int'($urandom_range(1, 3)), 0, 0, 1'b0);
    end

`ifdef SAR_CMP_TIMEOUT_EN
    run_conv(8'h00, 1, 3, 0, 1'b0);
    check("timeout_dout_const", dout, 8'h20);
    run_conv(8'h00, 1, 0, 0, 1'b0);
    check("timeout_cleared", timeout_flag, 0);
    // comp_valid arriving in the expiry cycle wins over the forced decision.
    run_conv(8'h00, CT, 0, 0, 1'b0);
`endif

    // Reset in the WAIT cycle of decision 4, then a fresh conversion.
    run_conv(8'hB2, 1, 0, SC + 8, 1'b0);
    run_conv(8'h5A, 1, 0, 0, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
